// File: rtl/vram_slot_arbiter_pkg.sv
// Shared types and slot constants for the video SRAM time-slot arbiter.
package vram_slot_arbiter_pkg;

    // Fixed slot positions within the 16-slot frame
    localparam logic [3:0] SLOT_TURN  = 4'd12;
    localparam logic [3:0] SLOT_FADDR = 4'd13;
    localparam logic [3:0] SLOT_F0    = 4'd14;
    localparam logic [3:0] SLOT_F1    = 4'd15;

    // One buffered CPU write: word address [17:1], data, active-low byte selects
    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
        logic        nuds;
        logic        nlds;
    } wbuf_entry_t;

    typedef enum logic [2:0] {
        SK_SETUP,
        SK_STROBE,
        SK_TURN,
        SK_FADDR,
        SK_FETCH
    } slot_kind_t;

    // Classify a slot number into the action that runs during it
    function automatic slot_kind_t slot_kind(input logic [3:0] slot);
        if (slot < SLOT_TURN)        return slot[0] ? SK_STROBE : SK_SETUP;
        else if (slot == SLOT_TURN)  return SK_TURN;
        else if (slot == SLOT_FADDR) return SK_FADDR;
        else                         return SK_FETCH;
    endfunction

endpackage

// File: rtl/vram_slot_arbiter_if.sv
// CPU write-snoop and video fetch request bus of the VRAM slot arbiter.
interface vram_slot_arbiter_if;
    logic        fetch_en;
    logic [16:0] fetch_addr;
    logic [15:0] fetch_data;
    logic        fetch_valid;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_nuds;
    logic        wr_nlds;
    logic        wr_ready;
    logic        wr_ovf;

    modport master (
        output fetch_en, fetch_addr, wr_req, wr_addr, wr_data, wr_nuds, wr_nlds,
        input  fetch_data, fetch_valid, wr_ready, wr_ovf
    );

    modport slave (
        input  fetch_en, fetch_addr, wr_req, wr_addr, wr_data, wr_nuds, wr_nlds,
        output fetch_data, fetch_valid, wr_ready, wr_ovf
    );
endinterface

// File: rtl/vram_slot_arbiter_wbuf.sv
// Write buffer FIFO (module vram_wbuf) for CPU framebuffer writes.
// Optional macro WRITE_COALESCE_EN: a write to the tail entry's address merges
// into that entry instead of taking a new one.
module vram_wbuf
    import vram_slot_arbiter_pkg::*;
#(
    parameter int WBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  wbuf_entry_t i_entry,
    input  logic        i_pop,
    output wbuf_entry_t o_head,
    output logic        o_empty,
    output logic        o_ready,
    output logic        o_ovf
);
    localparam int          AW       = $clog2(WBUF_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(WBUF_DEPTH);

    wbuf_entry_t   r_mem [WBUF_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ready;
    logic          r_ovf;

    logic [AW-1:0] w_tail;
    logic          w_full;
    logic          w_pop;
    logic          w_merge;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_count_next;
    wbuf_entry_t   w_merged;

    assign w_tail  = r_wptr - AW'(1);
    assign w_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;

`ifdef WRITE_COALESCE_EN
    // Merge only when the tail survives this cycle (not the last entry being popped)
    assign w_merge = i_push & ~o_empty & (r_mem[w_tail].addr == i_entry.addr)
                   & ~(w_pop & (r_count == (AW + 1)'(1)));
`else
    assign w_merge = 1'b0;
`endif

    assign w_push       = i_push & ~w_merge & ~w_full;
    assign w_drop       = i_push & ~w_merge & w_full;
    assign w_count_next = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

    // Tail entry with the incoming enabled byte lanes overlaid
    always_comb begin
        w_merged = r_mem[w_tail];
        if (!i_entry.nuds) w_merged.data[15:8] = i_entry.data[15:8];
        if (!i_entry.nlds) w_merged.data[7:0]  = i_entry.data[7:0];
        w_merged.nuds = r_mem[w_tail].nuds & i_entry.nuds;
        w_merged.nlds = r_mem[w_tail].nlds & i_entry.nlds;
    end

    // Pointers, occupancy, registered ready and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
            r_ready <= (w_count_next != FULL_CNT);
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Entry storage: contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (w_push)       r_mem[r_wptr] <= i_entry;
        else if (w_merge) r_mem[w_tail] <= w_merged;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_ready = r_ready;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing the single-ported 128Kx16 video SRAM between
// buffered CPU writes (slots 0-11) and the video fetch (slots 12-15).
// Optional macro WRITE_COALESCE_EN enables write merging in the buffer.
module vram_slot_arbiter
    import vram_slot_arbiter_pkg::*;
#(
    parameter int WBUF_DEPTH = 2
) (
    input  logic                C25M,
    input  logic                nRESET,
    input  logic [3:0]          SLOT,
    vram_slot_arbiter_if.slave  bus,
    output logic [16:0]         RA,
    output logic [15:0]         RD_o,
    output logic                RD_oe,
    input  logic [15:0]         RD_i,
    output logic                nRCSH,
    output logic                nRCSL,
    output logic                nRWE
);
    slot_kind_t  w_kind;
    wbuf_entry_t w_wr_entry;
    wbuf_entry_t w_head;
    logic        w_empty;
    logic        w_pop;

    logic [16:0] r_ra;
    logic [15:0] r_rdo;
    logic        r_oe;
    logic        r_armed;
    logic        r_nuds;
    logic        r_nlds;
    logic        r_pend;
    logic [15:0] r_fdata;
    logic        r_valid;

    assign w_kind     = slot_kind(SLOT);
    assign w_pop      = (w_kind == SK_SETUP) & ~w_empty;
    assign w_wr_entry = '{addr: bus.wr_addr, data: bus.wr_data,
                          nuds: bus.wr_nuds, nlds: bus.wr_nlds};

    vram_wbuf #(.WBUF_DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk     (C25M),
        .rst_n   (nRESET),
        .i_push  (bus.wr_req),
        .i_entry (w_wr_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_ready (bus.wr_ready),
        .o_ovf   (bus.wr_ovf)
    );

    // Slot-state registers: held address/data, write arm, fetch pending/result
    always_ff @(posedge C25M or negedge nRESET) begin
        if (!nRESET) begin
            r_ra    <= '0;
            r_rdo   <= '0;
            r_oe    <= 1'b0;
            r_armed <= 1'b0;
            r_nuds  <= 1'b1;
            r_nlds  <= 1'b1;
            r_pend  <= 1'b0;
            r_fdata <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (SLOT == SLOT_F1) & r_pend;
            case (w_kind)
                SK_SETUP: begin
                    r_armed <= ~w_empty;
                    if (!w_empty) begin
                        r_ra   <= w_head.addr;
                        r_rdo  <= w_head.data;
                        r_oe   <= 1'b1;
                        r_nuds <= w_head.nuds;
                        r_nlds <= w_head.nlds;
                    end
                end
                SK_STROBE: r_armed <= 1'b0;
                SK_TURN:   r_oe    <= 1'b0;
                SK_FADDR: begin
                    if (bus.fetch_en) r_ra <= bus.fetch_addr;
                    r_pend <= bus.fetch_en;
                end
                SK_FETCH: begin
                    if (SLOT == SLOT_F1) begin
                        if (r_pend) r_fdata <= RD_i;
                        r_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM pin drive for the current slot; reset forces the held (reset) values
    always_comb begin
        RA    = r_ra;
        RD_o  = r_rdo;
        RD_oe = r_oe;
        nRCSH = 1'b1;
        nRCSL = 1'b1;
        nRWE  = 1'b1;
        if (nRESET) begin
            case (w_kind)
                SK_SETUP: begin
                    if (!w_empty) begin
                        RA    = w_head.addr;
                        RD_o  = w_head.data;
                        RD_oe = 1'b1;
                    end
                end
                SK_STROBE: begin
                    // An entry with both lanes disabled still burns its slot pair
                    if (r_armed && !(r_nuds && r_nlds)) begin
                        nRWE  = 1'b0;
                        nRCSH = r_nuds;
                        nRCSL = r_nlds;
                    end
                end
                SK_TURN: RD_oe = 1'b0;
                SK_FADDR: begin
                    if (bus.fetch_en) RA = bus.fetch_addr;
                end
                SK_FETCH: begin
                    if (r_pend) begin
                        nRCSH = 1'b0;
                        nRCSL = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fetch_data  = r_fdata;
    assign bus.fetch_valid = r_valid;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter: a per-cycle vector table plus
// hand-written overflow, coalescing and async-reset sequences.
module tb_vram_slot_arbiter;

    logic        clk = 1'b0;
    logic        nRESET;
    logic [3:0]  SLOT;
    logic [16:0] RA;
    logic [15:0] RD_o;
    logic        RD_oe;
    logic [15:0] RD_i;
    logic        nRCSH, nRCSL, nRWE;

    int n_cmp = 0;
    int n_err = 0;

    vram_slot_arbiter_if bus();

    vram_slot_arbiter #(.WBUF_DEPTH(2)) dut (
        .C25M   (clk),
        .nRESET (nRESET),
        .SLOT   (SLOT),
        .bus    (bus),
        .RA     (RA),
        .RD_o   (RD_o),
        .RD_oe  (RD_oe),
        .RD_i   (RD_i),
        .nRCSH  (nRCSH),
        .nRCSL  (nRCSL),
        .nRWE   (nRWE)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [3:0]  slot;
        logic        req;
        logic [16:0] waddr;
        logic [15:0] wdata;
        logic        nuds, nlds;
        logic        fen;
        logic [16:0] faddr;
        logic [15:0] rdi;
        logic [16:0] e_ra;
        logic [15:0] e_rdo;
        logic        e_oe, e_we, e_csh, e_csl, e_valid;
        logic [15:0] e_fdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [3:0] slot, input logic req, input logic [16:0] waddr,
        input logic [15:0] wdata, input logic nuds, input logic nlds,
        input logic fen, input logic [16:0] faddr, input logic [15:0] rdi,
        input logic [16:0] e_ra, input logic [15:0] e_rdo, input logic e_oe,
        input logic e_we, input logic e_csh, input logic e_csl,
        input logic e_valid, input logic [15:0] e_fdata);
        vec_t v;
        v.slot = slot; v.req = req; v.waddr = waddr; v.wdata = wdata;
        v.nuds = nuds; v.nlds = nlds; v.fen = fen; v.faddr = faddr; v.rdi = rdi;
        v.e_ra = e_ra; v.e_rdo = e_rdo; v.e_oe = e_oe; v.e_we = e_we;
        v.e_csh = e_csh; v.e_csl = e_csl; v.e_valid = e_valid; v.e_fdata = e_fdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic req, input logic [16:0] a, input logic [15:0] d,
                          input logic nu, input logic nl);
        bus.wr_req = req; bus.wr_addr = a; bus.wr_data = d;
        bus.wr_nuds = nu; bus.wr_nlds = nl;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".RA"},     32'(RA), 32'h0);
        chk({tag, ".RD_o"},   32'(RD_o), 32'h0);
        chk({tag, ".RD_oe"},  32'(RD_oe), 32'h0);
        chk({tag, ".cs_we"},  32'({nRCSH, nRCSL, nRWE}), 32'h7);
        chk({tag, ".fdata"},  32'(bus.fetch_data), 32'h0);
        chk({tag, ".fvalid"}, 32'(bus.fetch_valid), 32'h0);
        chk({tag, ".ready"},  32'(bus.wr_ready), 32'h1);
        chk({tag, ".ovf"},    32'(bus.wr_ovf), 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0;
        SLOT   = 4'd13;
        RD_i   = 16'h0;
        bus.fetch_en = 1'b1;
        bus.fetch_addr = 17'h01234;
        set_wr(1'b0, 17'h0, 16'h0, 1'b1, 1'b1);

        // slot, req, waddr, wdata, nuds, nlds, fen, faddr, rdi | RA, RD_o, oe, nRWE, nRCSH, nRCSL, valid, fdata
        tbl.push_back(mk(4'd0,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h0,     16'h0,    0, 1, 1, 1, 0, 16'h0));
        tbl.push_back(mk(4'd1,  1, 17'h00040, 16'hA55A, 0, 1, 0, 17'h0,    16'h0,    17'h0,     16'h0,    0, 1, 1, 1, 0, 16'h0));
        tbl.push_back(mk(4'd2,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00040, 16'hA55A, 1, 1, 1, 1, 0, 16'h0));
        tbl.push_back(mk(4'd3,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00040, 16'hA55A, 1, 0, 0, 1, 0, 16'h0));
        tbl.push_back(mk(4'd4,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00040, 16'hA55A, 1, 1, 1, 1, 0, 16'h0));
        tbl.push_back(mk(4'd11, 0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00040, 16'hA55A, 1, 1, 1, 1, 0, 16'h0));
        tbl.push_back(mk(4'd12, 1, 17'h1FFFF, 16'h1234, 0, 0, 0, 17'h0,    16'h0,    17'h00040, 16'hA55A, 0, 1, 1, 1, 0, 16'h0));
        tbl.push_back(mk(4'd13, 0, 17'h0,     16'h0,    1, 1, 1, 17'h01234,16'h0,    17'h01234, 16'hA55A, 0, 1, 1, 1, 0, 16'h0));
        tbl.push_back(mk(4'd14, 0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'hBEEF, 17'h01234, 16'hA55A, 0, 1, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'd15, 0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'hBEEF, 17'h01234, 16'hA55A, 0, 1, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'd0,  1, 17'h00ABC, 16'h0F0F, 1, 1, 0, 17'h0,    16'h0,    17'h1FFFF, 16'h1234, 1, 1, 1, 1, 1, 16'hBEEF));
        tbl.push_back(mk(4'd1,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h1FFFF, 16'h1234, 1, 0, 0, 0, 0, 16'hBEEF));
        tbl.push_back(mk(4'd2,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00ABC, 16'h0F0F, 1, 1, 1, 1, 0, 16'hBEEF));
        tbl.push_back(mk(4'd3,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00ABC, 16'h0F0F, 1, 1, 1, 1, 0, 16'hBEEF));
        tbl.push_back(mk(4'd4,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00ABC, 16'h0F0F, 1, 1, 1, 1, 0, 16'hBEEF));
        tbl.push_back(mk(4'd12, 0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00ABC, 16'h0F0F, 0, 1, 1, 1, 0, 16'hBEEF));
        tbl.push_back(mk(4'd13, 0, 17'h0,     16'h0,    1, 1, 0, 17'h00555,16'h0,    17'h00ABC, 16'h0F0F, 0, 1, 1, 1, 0, 16'hBEEF));
        tbl.push_back(mk(4'd14, 0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'hDEAD, 17'h00ABC, 16'h0F0F, 0, 1, 1, 1, 0, 16'hBEEF));
        tbl.push_back(mk(4'd15, 0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'hDEAD, 17'h00ABC, 16'h0F0F, 0, 1, 1, 1, 0, 16'hBEEF));
        tbl.push_back(mk(4'd0,  0, 17'h0,     16'h0,    1, 1, 0, 17'h0,    16'h0,    17'h00ABC, 16'h0F0F, 0, 1, 1, 1, 0, 16'hBEEF));

        // Reset state, with a fetch request present on slot 13
        step();
        step();
        chk_reset_vals("reset");

        nRESET = 1'b1;
        foreach (tbl[i]) begin
            SLOT = tbl[i].slot;
            set_wr(tbl[i].req, tbl[i].waddr, tbl[i].wdata, tbl[i].nuds, tbl[i].nlds);
            bus.fetch_en = tbl[i].fen;
            bus.fetch_addr = tbl[i].faddr;
            RD_i = tbl[i].rdi;
            #2;
            chk($sformatf("v%0d.RA", i),     32'(RA), 32'(tbl[i].e_ra));
            chk($sformatf("v%0d.RD_o", i),   32'(RD_o), 32'(tbl[i].e_rdo));
            chk($sformatf("v%0d.RD_oe", i),  32'(RD_oe), 32'(tbl[i].e_oe));
            chk($sformatf("v%0d.nRWE", i),   32'(nRWE), 32'(tbl[i].e_we));
            chk($sformatf("v%0d.nRCSH", i),  32'(nRCSH), 32'(tbl[i].e_csh));
            chk($sformatf("v%0d.nRCSL", i),  32'(nRCSL), 32'(tbl[i].e_csl));
            chk($sformatf("v%0d.fvalid", i), 32'(bus.fetch_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d.fdata", i),  32'(bus.fetch_data), 32'(tbl[i].e_fdata));
            chk($sformatf("v%0d.ready", i),  32'(bus.wr_ready), 32'h1);
            step();
        end
        set_wr(1'b0, 17'h0, 16'h0, 1'b1, 1'b1);
        bus.fetch_en = 1'b0;
        RD_i = 16'h0;

        // Overflow: three writes with no SETUP slot, depth 2
        SLOT = 4'd12;
        set_wr(1'b1, 17'h00100, 16'h0001, 1'b0, 1'b0);
        step();
        chk("ovf.ready1", 32'(bus.wr_ready), 32'h1);
        set_wr(1'b1, 17'h00200, 16'h0002, 1'b0, 1'b0);
        step();
        chk("ovf.ready2", 32'(bus.wr_ready), 32'h0);
        chk("ovf.ovf2",   32'(bus.wr_ovf), 32'h0);
        set_wr(1'b1, 17'h00300, 16'h0003, 1'b0, 1'b0);
        step();
        chk("ovf.ovf3",   32'(bus.wr_ovf), 32'h1);
        chk("ovf.ready3", 32'(bus.wr_ready), 32'h0);
        set_wr(1'b0, 17'h0, 16'h0, 1'b1, 1'b1);
        SLOT = 4'd0; #2;
        chk("ovf.s0.RA", 32'(RA), 32'h00100);
        step();
        SLOT = 4'd1; #2;
        chk("ovf.s1.nRWE",  32'(nRWE), 32'h0);
        chk("ovf.s1.ready", 32'(bus.wr_ready), 32'h1);
        step();
        SLOT = 4'd2; #2;
        chk("ovf.s2.RA",   32'(RA), 32'h00200);
        chk("ovf.s2.RD_o", 32'(RD_o), 32'h0002);
        step();
        SLOT = 4'd3; #2;
        chk("ovf.s3.nRWE", 32'(nRWE), 32'h0);
        step();
        SLOT = 4'd4; #2;
        chk("ovf.s4.RA", 32'(RA), 32'h00200);
        step();
        SLOT = 4'd5; #2;
        chk("ovf.s5.nRWE", 32'(nRWE), 32'h1);
        chk("ovf.sticky",  32'(bus.wr_ovf), 32'h1);
        step();

        // Same address, lower byte then upper byte
        SLOT = 4'd12;
        set_wr(1'b1, 17'h00077, 16'h00CC, 1'b1, 1'b0);
        step();
        SLOT = 4'd13;
        set_wr(1'b1, 17'h00077, 16'hDD00, 1'b0, 1'b1);
        step();
        set_wr(1'b0, 17'h0, 16'h0, 1'b1, 1'b1);
        SLOT = 4'd14; step();
        SLOT = 4'd15; step();
        SLOT = 4'd0; #2;
        chk("coal.s0.RA", 32'(RA), 32'h00077);
`ifdef WRITE_COALESCE_EN
        chk("coal.s0.RD_o", 32'(RD_o), 32'hDDCC);
`else
        chk("coal.s0.RD_o", 32'(RD_o), 32'h00CC);
`endif
        step();
        SLOT = 4'd1; #2;
`ifdef WRITE_COALESCE_EN
        chk("coal.s1.cs_we", 32'({nRCSH, nRCSL, nRWE}), 32'h0);
`else
        chk("coal.s1.cs_we", 32'({nRCSH, nRCSL, nRWE}), 32'h4);
`endif
        step();
        SLOT = 4'd2; #2;
`ifndef WRITE_COALESCE_EN
        chk("coal.s2.RD_o", 32'(RD_o), 32'hDD00);
`else
        chk("coal.s2.RD_o", 32'(RD_o), 32'hDDCC);
`endif
        step();
        SLOT = 4'd3; #2;
`ifdef WRITE_COALESCE_EN
        chk("coal.s3.cs_we", 32'({nRCSH, nRCSL, nRWE}), 32'h7);
`else
        chk("coal.s3.cs_we", 32'({nRCSH, nRCSL, nRWE}), 32'h2);
`endif
        step();
        SLOT = 4'd4; step();

        // Asynchronous reset in the middle of a write strobe
        SLOT = 4'd5;
        set_wr(1'b1, 17'h00055, 16'h1111, 1'b0, 1'b0);
        step();
        set_wr(1'b0, 17'h0, 16'h0, 1'b1, 1'b1);
        SLOT = 4'd6; #2;
        chk("rst.s6.RA", 32'(RA), 32'h00055);
        step();
        SLOT = 4'd7; #2;
        chk("rst.s7.nRWE", 32'(nRWE), 32'h0);
        #5;
        nRESET = 1'b0;
        #1;
        chk_reset_vals("midrst");
        step();
        nRESET = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
